// File: rtl/wb_stage.sv
// Writeback stage: buffers ALU results in a FIFO and retires them to GPRs and RFLAGS.
// Optional WB_BYPASS_EN adds forwarding ports that mirror the GPR write port.
module wb_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exe_mem,
  output logic             mem_exe,
  input  logic [127:0]     result,
  input  logic [63:0]      rflags,
  input  logic [3:0]       dest_lo,
  input  logic [3:0]       dest_hi,
  input  logic             wide,
  input  logic             wr_gpr,
  input  logic             wr_flags,
  output logic             gpr_we,
  output logic [3:0]       gpr_waddr,
  output logic [63:0]      gpr_wdata,
  output logic             rflags_we,
  output logic [63:0]      rflags_wdata,
  output logic [CNT_W-1:0] retired,
`ifdef WB_BYPASS_EN
  output logic             busy,
  output logic             fwd_valid,
  output logic [3:0]       fwd_reg,
  output logic [63:0]      fwd_data,
  output logic             fwd_flags_valid
`else
  output logic             busy
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [127:0] result;
    logic [63:0]  rflags;
    logic [3:0]   dest_lo;
    logic [3:0]   dest_hi;
    logic         wide;
    logic         wr_gpr;
    logic         wr_flags;
  } wb_ent_t;

  typedef enum logic [1:0] {
    IDLE,
    WB_LO,
    WB_HI
  } state_e;

  wb_ent_t          mem [DEPTH];
  wb_ent_t          ent_in;
  wb_ent_t          hold_q, hold_d;
  state_e           state_q, state_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             hi_q, hi_d;
  logic             empty, full, push, pop, fin, sel_hi;

  assign ent_in = '{result, rflags, dest_lo, dest_hi, wide, wr_gpr, wr_flags};

  // Ready is a function of the registered count only
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign mem_exe = !full;
  assign push    = exe_mem && !full;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    hi_d      = hi_q;
    retired_d = retired_q;
    pop       = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = WB_LO;
        end
      end
      WB_LO: begin
        hi_d = 1'b0;
        if (hold_q.wide && hold_q.wr_gpr) begin
          state_d = WB_HI;
        end else begin
          fin = 1'b1;
        end
      end
      WB_HI: begin
        hi_d = 1'b1;
        fin  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      retired_d = retired_q + CNT_W'(1);
      if (!empty) begin
        pop     = 1'b1;
        state_d = WB_LO;
      end else begin
        state_d = IDLE;
      end
    end
    if (pop) begin
      hold_d = mem[rptr_q];
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= ent_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      hi_q      <= 1'b0;
      retired_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      hi_q      <= hi_d;
      retired_q <= retired_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // In IDLE the port keeps showing whichever half was written last
  always_comb begin
    sel_hi       = (state_q == WB_HI) || ((state_q == IDLE) && hi_q);
    gpr_we       = ((state_q == WB_LO) && hold_q.wr_gpr) ||
                   (state_q == WB_HI);
    gpr_waddr    = sel_hi ? hold_q.dest_hi : hold_q.dest_lo;
    gpr_wdata    = sel_hi ? hold_q.result[127:64] : hold_q.result[63:0];
    rflags_we    = (state_q == WB_LO) && hold_q.wr_flags;
    rflags_wdata = hold_q.rflags;
  end

  assign retired = retired_q;
  assign busy    = !empty || (state_q != IDLE);

`ifdef WB_BYPASS_EN
  assign fwd_valid       = gpr_we;
  assign fwd_reg         = gpr_waddr;
  assign fwd_data        = gpr_wdata;
  assign fwd_flags_valid = rflags_we;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes queued at accept,
// compared in order as the stage drives its write ports.
module tb_wb_stage;

  logic         clk;
  logic         rst_n;
  logic         exe_mem;
  logic         mem_exe;
  logic [127:0] result;
  logic [63:0]  rflags;
  logic [3:0]   dest_lo;
  logic [3:0]   dest_hi;
  logic         wide;
  logic         wr_gpr;
  logic         wr_flags;
  logic         gpr_we;
  logic [3:0]   gpr_waddr;
  logic [63:0]  gpr_wdata;
  logic         rflags_we;
  logic [63:0]  rflags_wdata;
  logic [63:0]  retired;
  logic         busy;
`ifdef WB_BYPASS_EN
  logic         fwd_valid;
  logic [3:0]   fwd_reg;
  logic [63:0]  fwd_data;
  logic         fwd_flags_valid;
`endif

  wb_stage #(.DEPTH(2), .CNT_W(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .exe_mem(exe_mem),
    .mem_exe(mem_exe),
    .result(result),
    .rflags(rflags),
    .dest_lo(dest_lo),
    .dest_hi(dest_hi),
    .wide(wide),
    .wr_gpr(wr_gpr),
    .wr_flags(wr_flags),
    .gpr_we(gpr_we),
    .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata),
    .rflags_we(rflags_we),
    .rflags_wdata(rflags_wdata),
    .retired(retired),
`ifdef WB_BYPASS_EN
    .busy(busy),
    .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg),
    .fwd_data(fwd_data),
    .fwd_flags_valid(fwd_flags_valid)
`else
    .busy(busy)
`endif
  );

  typedef struct packed {
    logic [3:0]  a;
    logic [63:0] d;
  } gw_t;

  gw_t         gq[$];
  logic [63:0] fq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_ret = 0;
  logic [31:0] hist = '0;
  bit          saw_full = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    gw_t         e;
    logic [63:0] f;
    if (rst_n) begin
      hist = {hist[30:0], gpr_we};
      if (!mem_exe) saw_full = 1;
      if (gpr_we) begin
        if (gq.size() == 0) begin
          chk("gpr_extra", 128'(gpr_we), 0);
        end else begin
          e = gq.pop_front();
          chk("gpr_addr", 128'(gpr_waddr), 128'(e.a));
          chk("gpr_data", 128'(gpr_wdata), 128'(e.d));
`ifdef WB_BYPASS_EN
          chk("fwd_reg", 128'(fwd_reg), 128'(e.a));
          chk("fwd_data", 128'(fwd_data), 128'(e.d));
          chk("fwd_valid", 128'(fwd_valid), 1);
`endif
        end
      end
      if (rflags_we) begin
        if (fq.size() == 0) begin
          chk("flg_extra", 128'(rflags_we), 0);
        end else begin
          f = fq.pop_front();
          chk("flg_data", 128'(rflags_wdata), 128'(f));
        end
      end
    end
  end

  // Called in the posedge+1 phase; returns in the same phase
  task automatic push_op(input logic [127:0] r, input logic [63:0] f,
                         input logic [3:0] lo, input logic [3:0] hi,
                         input logic w, input logic g, input logic fl);
    bit  acc;
    gw_t e;
    result = r; rflags = f; dest_lo = lo; dest_hi = hi;
    wide = w; wr_gpr = g; wr_flags = fl; exe_mem = 1'b1;
    acc = 0;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = mem_exe;
      @(posedge clk);
    end
    if (!acc) begin
      chk("accept_timeout", 128'(mem_exe), 1);
    end else begin
      exp_ret++;
      if (g) begin
        e.a = lo; e.d = r[63:0];
        gq.push_back(e);
      end
      if (w && g) begin
        e.a = hi; e.d = r[127:64];
        gq.push_back(e);
      end
      if (fl) fq.push_back(f);
    end
    #1 exe_mem = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({tag, "_idle"}, 128'(busy), 0);
    chk({tag, "_retired"}, 128'(retired), 128'(exp_ret));
    chk({tag, "_gq_left"}, 128'(gq.size()), 0);
    chk({tag, "_fq_left"}, 128'(fq.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] h;
    rst_n = 1'b0; exe_mem = 1'b0; result = '0; rflags = '0;
    dest_lo = '0; dest_hi = '0; wide = 1'b0; wr_gpr = 1'b0; wr_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpr_we", 128'(gpr_we), 0);
    chk("rst_waddr", 128'(gpr_waddr), 0);
    chk("rst_wdata", 128'(gpr_wdata), 0);
    chk("rst_rflags_we", 128'(rflags_we), 0);
    chk("rst_rflags_wdata", 128'(rflags_wdata), 0);
    chk("rst_retired", 128'(retired), 0);
    chk("rst_busy", 128'(busy), 0);
`ifdef WB_BYPASS_EN
    chk("rst_fwd", 128'({fwd_valid, fwd_reg, fwd_data, fwd_flags_valid}), 0);
`endif
    rst_n = 1'b1;
    #1 chk("rst_mem_exe", 128'(mem_exe), 1);

    // Narrow write with explicit latency checks
    push_op(128'h42, 64'h46, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_early_we", 128'(gpr_we), 0);
    @(negedge clk);
    chk("lat_gpr_we", 128'(gpr_we), 1);
    chk("lat_rflags_we", 128'(rflags_we), 1);
    @(negedge clk);
    chk("narrow_retired", 128'(retired), 1);
    @(posedge clk);
    #1;
    wait_idle("narrow");

    // Wide write
    push_op({64'hDEAD, 64'hBEEF}, 64'h0202, 4'd0, 4'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("wide_lo_addr", 128'(gpr_waddr), 0);
    @(negedge clk);
    chk("wide_hi_we", 128'(gpr_we), 1);
    chk("wide_hi_addr", 128'(gpr_waddr), 2);
    chk("wide_hi_flags", 128'(rflags_we), 0);
    @(posedge clk);
    #1;
    wait_idle("wide");
    chk("wide_hold_addr", 128'(gpr_waddr), 2);
    chk("wide_hold_data", 128'(gpr_wdata), 128'(64'hDEAD));

    // Backpressure: 4 wide ops back to back
    saw_full = 0;
    for (int i = 0; i < 4; i++) begin
      push_op({64'h1000 + 64'(i), 64'h2000 + 64'(i)}, 64'(i),
              4'(i + 4), 4'(i + 8), 1'b1, 1'b1, 1'b1);
    end
    wait_idle("bp");
    chk("bp_saw_full", 128'(saw_full), 1);

    // Streaming 8 narrow ops
    hist = '0;
    for (int i = 0; i < 8; i++) begin
      push_op(128'(64'hA0 + 64'(i)), 64'(i), 4'(i), 4'd0, 1'b0, 1'b1, 1'b0);
    end
    wait_idle("stream");
    h = hist;
    for (int k = 0; k < 32 && h != 0 && !h[0]; k++) h = h >> 1;
    chk("stream_run", 128'(h), 128'(32'hFF));

    // Random mix with idle gaps
    for (int i = 0; i < 24; i++) begin
      logic [127:0] r;
      logic [3:0]   lo;
      r  = {$urandom, $urandom, $urandom, $urandom};
      lo = 4'($urandom_range(0, 15));
      push_op(r, {$urandom, $urandom}, lo,
              ($urandom_range(0, 3) == 0) ? lo : 4'($urandom_range(0, 15)),
              1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle("rand");

    // Flags-only op
    push_op(128'h77, 64'h8D5, 4'd7, 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("flg_only_gpr_we", 128'(gpr_we), 0);
    chk("flg_only_rflags_we", 128'(rflags_we), 1);
`ifdef WB_BYPASS_EN
    chk("flg_only_fwd_valid", 128'(fwd_valid), 0);
    chk("flg_only_fwd_flags", 128'(fwd_flags_valid), 1);
`endif
    @(posedge clk);
    #1;
    wait_idle("flags");

    // Reset during WB_LO of a wide op
    push_op({64'h5555, 64'h6666}, 64'h1, 4'd5, 4'd6, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_we", 128'(gpr_we), 0);
    chk("rst_async_busy", 128'(busy), 0);
    gq.delete();
    fq.delete();
    exp_ret = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_mid_retired", 128'(retired), 0);
    chk("rst_mid_mem_exe", 128'(mem_exe), 1);
    chk("rst_mid_busy", 128'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    wait_idle("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the execute ALU.
- Consumes the ALU's registered result, rflags and destination info through the exe_mem / mem_exe handshake.
- Buffers results in a small FIFO and retires them into the GPR file and RFLAGS register.
- 128-bit results (wide ops, e.g. RDX:RAX) are split into two sequential 64-bit register writes.

Parameters:
- DEPTH, 2, number of input FIFO entries (power of two, at least 2).
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exe_mem  in  1  valid from ALU: result/rflags/dest fields are meaningful this cycle.
- mem_exe  out  1  ready to ALU; transfer occurs on an edge where exe_mem && mem_exe.
- result  in  128  ALU result; [63:0] low half, [127:64] high half.
- rflags  in  64  flags produced by the instruction.
- dest_lo  in  4  GPR index for result[63:0].
- dest_hi  in  4  GPR index for result[127:64]; used only when wide=1.
- wide  in  1  instruction writes both halves.
- wr_gpr  in  1  instruction writes a GPR (0 for flags-only ops, e.g. CMP).
- wr_flags  in  1  instruction updates RFLAGS.
- gpr_we  out  1  GPR write strobe.
- gpr_waddr  out  4  GPR write index.
- gpr_wdata  out  64  GPR write data.
- rflags_we  out  1  RFLAGS write strobe.
- rflags_wdata  out  64  RFLAGS write data.
- retired  out  CNT_W  count of fully retired instructions.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, FSM IDLE, holding register cleared.
  - gpr_we=0, gpr_waddr=0, gpr_wdata=0.
  - rflags_we=0, rflags_wdata=0.
  - retired=0, busy=0.
  - mem_exe=1 once reset deasserts.
  - In-flight entries are dropped, with no partial write.
- Input FIFO:
  - mem_exe = !full. It depends only on the registered fill count, never on the same-cycle pop.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Push writes {result, rflags, dest_lo, dest_hi, wide, wr_gpr, wr_flags} at the write pointer.
  - Pointers wrap modulo DEPTH; the fill count uses log2(DEPTH)+1 bits.
  - A push in the same cycle as a pop leaves the count unchanged.
- FSM states: IDLE, WB_LO, WB_HI.
  - IDLE: if the FIFO is non-empty at the edge, pop the head into the holding register and go to WB_LO; else stay.
  - WB_LO:
    - gpr_we=wr_gpr, gpr_waddr=dest_lo, gpr_wdata=result[63:0].
    - rflags_we=wr_flags, rflags_wdata=rflags.
    - If wide&&wr_gpr, go to WB_HI.
    - Else the instruction retires (retired+1). If the FIFO is non-empty, pop the next entry and stay in WB_LO; else go to IDLE.
  - WB_HI:
    - gpr_we=1, gpr_waddr=dest_hi, gpr_wdata=result[127:64], rflags_we=0.
    - Then retire and continue exactly as at the end of WB_LO.
  - Outputs are decoded from state plus the holding register only, so they are glitch-free.
  - Strobes are 0 in IDLE; addr/data hold their last values.
- Latency and throughput:
  - Entry accepted at edge N drives its first write during the cycle after edge N+1.
  - Throughput: 1 narrow instruction per cycle; a wide instruction takes 2 cycles.
- Edge cases:
  - A wide op with dest_hi==dest_lo performs both writes; the high write lands last and wins.
  - wr_gpr=0 with wr_flags=0 still occupies one WB_LO cycle and increments retired.
  - retired wraps at 2^CNT_W silently.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, adds these output ports, which mirror the GPR write port for ALU operand forwarding:
  - fwd_valid  1  equals gpr_we.
  - fwd_reg  4  equals gpr_waddr.
  - fwd_data  64  equals gpr_wdata.
- Also adds fwd_flags_valid  1, which equals rflags_we.
- Reset values of all bypass ports are 0.
- When not defined, these ports and their logic are absent and the module is otherwise identical.

Test Plan:
- Narrow write: reset, push result=0x...0042, dest_lo=3, wr_gpr=1, wr_flags=1, rflags=0x46 -> one cycle later gpr_we=1, addr=3, data=0x42, rflags_we=1, wdata=0x46; retired=1.
- Wide write: push result={0xDEAD, 0xBEEF}, dest_lo=0, dest_hi=2, wide=1 -> consecutive cycles write (0,0xBEEF) then (2,0xDEAD); rflags_we only in the first cycle; retired increments once.
- Backpressure: hold exe_mem=1 with 4 wide ops pushed back-to-back -> mem_exe drops to 0 after the FIFO fills; no entry is lost or duplicated; write order matches push order; retired=4.
- Streaming: 8 narrow ops, one per cycle -> one gpr_we per cycle, no bubbles after the first; FSM never enters IDLE mid-stream.
- Reset mid-op: assert rst_n=0 during WB_LO of a wide op -> gpr_we=0 immediately (async); after release FIFO empty, retired=0, mem_exe=1, and the high write never occurs.
- Flags-only: push wr_gpr=0, wr_flags=1 -> gpr_we stays 0, rflags_we=1 for one cycle; with WB_BYPASS_EN, fwd_valid=0 and fwd_flags_valid=1.
